k423_if_bpu_lhp: RTL and testbench

- Parametrised two-level local-history branch predictor for the IF-stage BPU; next generation of the per-PC history + pattern table predictor.
- Per-PC history table (BHT) indexes a pattern table (PHT) of saturating counters, using one of two selectable hash modes.
- Additions over the previous generation: configurable history and counter widths, in-block counter read-modify-write, same-cycle update-to-predict bypass, and a sequential table-initialisation FSM with flush.

---
 rtl/k423_if_bpu_lhp.sv | 95 +++++++++
 tb/tb_k423_if_bpu_lhp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/k423_if_bpu_lhp.sv
// k423_if_bpu_lhp: two-level local-history branch predictor with init/flush FSM and update bypass
// Per-PC history (BHT) selects a saturating counter in the PHT; same-cycle updates forward into the prediction.
module k423_if_bpu_lhp #(
   parameter int ADDR_W    = 32,
   parameter int BHT_DEPTH = 64,
   parameter int PHT_DEPTH = 256,
   parameter int HIST_W    = 4,
   parameter int CNT_W     = 2,
   parameter int HASH_MODE = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] prd_pc_i,
   input  logic              upd_vld_i,
   input  logic              upd_tkn_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   output logic              rdy_o,
   output logic              prd_tkn_o,
   output logic [CNT_W-1:0]  prd_cnt_o,
   output logic [HIST_W-1:0] prd_hist_o
);
   localparam int BHT_AW = $clog2(BHT_DEPTH);
   localparam int PHT_AW = $clog2(PHT_DEPTH);
   localparam int N      = BHT_DEPTH > PHT_DEPTH ? BHT_DEPTH : PHT_DEPTH;
   localparam int IW     = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] WNT = {1'b0, {(CNT_W-1){1'b1}}};

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [IW-1:0]     idx;
   logic [HIST_W-1:0] bht [BHT_DEPTH];
   logic [CNT_W-1:0]  pht [PHT_DEPTH];

   logic              upd_en;
   logic [BHT_AW-1:0] u_bidx, p_bidx;
   logic [PHT_AW-1:0] u_pidx, p_pidx;
   logic [HIST_W-1:0] u_h, u_hn, p_h;
   logic [HIST_W:0]   u_hs;
   logic [CNT_W-1:0]  u_c, u_cn, p_c;
   logic              unused;

   // Mode 0 folds history into the top PC bits; mode 1 into the bottom ones.
   function automatic logic [PHT_AW-1:0] hash(input logic [ADDR_W-1:0] pc, input logic [HIST_W-1:0] h);
      logic [PHT_AW-1:0] hx;
      hx = PHT_AW'(h);
      return pc[PHT_AW+1:2] ^ (HASH_MODE == 0 ? hx << (PHT_AW - HIST_W) : hx);
   endfunction

   assign unused = ^{prd_pc_i, upd_pc_i};
   assign upd_en = rdy_o & upd_vld_i & ~flush_i;

   always_comb begin
      u_bidx = upd_pc_i[BHT_AW+1:2];
      u_h    = bht[u_bidx];
      u_pidx = hash(upd_pc_i, u_h);
      u_c    = pht[u_pidx];
      u_cn   = upd_tkn_i ? (&u_c ? u_c : u_c + 1'b1) : (|u_c ? u_c - 1'b1 : u_c);
      u_hs   = {u_h, upd_tkn_i};
      u_hn   = u_hs[HIST_W-1:0];
      p_bidx = prd_pc_i[BHT_AW+1:2];
      p_h    = (upd_en && p_bidx == u_bidx) ? u_hn : bht[p_bidx];
      p_pidx = hash(prd_pc_i, p_h);
      p_c    = (upd_en && p_pidx == u_pidx) ? u_cn : pht[p_pidx];
   end

   assign prd_hist_o = rdy_o ? p_h : '0;
   assign prd_cnt_o  = rdy_o ? p_c : '0;
   assign prd_tkn_o  = rdy_o & p_c[CNT_W-1];

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state <= INIT;
         idx   <= '0;
         rdy_o <= 1'b0;
      end else if (state == INIT) begin
         idx <= idx + 1'b1;
         if (idx == IW'(N - 1)) begin
            state <= RUN;
            rdy_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == INIT) begin
         if (idx < IW'(BHT_DEPTH)) bht[idx[BHT_AW-1:0]] <= '0;
         if (idx < IW'(PHT_DEPTH)) pht[idx[PHT_AW-1:0]] <= WNT;
      end else if (upd_en && !rst_i) begin
         bht[u_bidx] <= u_hn;
         pht[u_pidx] <= u_cn;
      end
   end
endmodule

// File: tb/tb_k423_if_bpu_lhp.sv
// tb_k423_if_bpu_lhp: directed vectors over four predictor configurations
// u0 default, u1 HASH_MODE=1, u2 HIST_W=1, u3 CNT_W=3.
module tb_k423_if_bpu_lhp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic uv [4];
   logic ut [4];
   logic [31:0] upc [4];
   logic [31:0] ppc [4];
   logic rdy0, rdy1, rdy2, rdy3, tkn0, tkn1, tkn2, tkn3;
   logic [1:0] cnt0, cnt1, cnt2;
   logic [2:0] cnt3;
   logic [3:0] hist0, hist1, hist3;
   logic [0:0] hist2;
   int nvec = 0;
   int nmis = 0;

   typedef struct {
      bit uv; bit ut; logic [31:0] upc; logic [31:0] ppc; int ec; int eh; bit et;
   } vec_t;
   vec_t tv [17];

   always #5 clk = ~clk;

   k423_if_bpu_lhp u0 (.clk_i(clk), .rst_i(rst), .flush_i(flush), .prd_pc_i(ppc[0]), .upd_vld_i(uv[0]),
      .upd_tkn_i(ut[0]), .upd_pc_i(upc[0]), .rdy_o(rdy0), .prd_tkn_o(tkn0), .prd_cnt_o(cnt0), .prd_hist_o(hist0));
   k423_if_bpu_lhp #(.HASH_MODE(1)) u1 (.clk_i(clk), .rst_i(rst), .flush_i(1'b0), .prd_pc_i(ppc[1]), .upd_vld_i(uv[1]),
      .upd_tkn_i(ut[1]), .upd_pc_i(upc[1]), .rdy_o(rdy1), .prd_tkn_o(tkn1), .prd_cnt_o(cnt1), .prd_hist_o(hist1));
   k423_if_bpu_lhp #(.HIST_W(1)) u2 (.clk_i(clk), .rst_i(rst), .flush_i(1'b0), .prd_pc_i(ppc[2]), .upd_vld_i(uv[2]),
      .upd_tkn_i(ut[2]), .upd_pc_i(upc[2]), .rdy_o(rdy2), .prd_tkn_o(tkn2), .prd_cnt_o(cnt2), .prd_hist_o(hist2));
   k423_if_bpu_lhp #(.CNT_W(3)) u3 (.clk_i(clk), .rst_i(rst), .flush_i(1'b0), .prd_pc_i(ppc[3]), .upd_vld_i(uv[3]),
      .upd_tkn_i(ut[3]), .upd_pc_i(upc[3]), .rdy_o(rdy3), .prd_tkn_o(tkn3), .prd_cnt_o(cnt3), .prd_hist_o(hist3));

   function automatic int gcnt(int s);
      return s == 0 ? int'(cnt0) : s == 1 ? int'(cnt1) : s == 2 ? int'(cnt2) : int'(cnt3);
   endfunction
   function automatic int ghist(int s);
      return s == 0 ? int'(hist0) : s == 1 ? int'(hist1) : s == 2 ? int'(hist2) : int'(hist3);
   endfunction
   function automatic int gtkn(int s);
      return s == 0 ? int'(tkn0) : s == 1 ? int'(tkn1) : s == 2 ? int'(tkn2) : int'(tkn3);
   endfunction
   function automatic int grdy(int s);
      return s == 0 ? int'(rdy0) : s == 1 ? int'(rdy1) : s == 2 ? int'(rdy2) : int'(rdy3);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus on instance s and check the combinational prediction before the edge.
   task automatic step(input int s, input bit v, input bit t, input logic [31:0] up, input logic [31:0] pp,
                       input int ec, input int eh, input int et, input string nm);
      @(negedge clk);
      uv[s] = v; ut[s] = t; upc[s] = up; ppc[s] = pp;
      #1;
      chk({nm, ".cnt"}, gcnt(s), ec);
      chk({nm, ".hist"}, ghist(s), eh);
      chk({nm, ".tkn"}, gtkn(s), et);
   endtask

   // Count rising edges from now until rdy goes high, bounded.
   task automatic wait_rdy(input int s, input int exp, input string nm);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (grdy(s) == 0 && n < 1000);
      chk(nm, n, exp);
   endtask

   initial begin
      tv[0]  = '{1, 1, 32'h1000, 32'h1000, 1, 1, 0};
      tv[1]  = '{1, 1, 32'h1000, 32'h1000, 1, 3, 0};
      tv[2]  = '{1, 1, 32'h1000, 32'h1000, 1, 7, 0};
      tv[3]  = '{1, 1, 32'h1000, 32'h1000, 1, 15, 0};
      tv[4]  = '{1, 1, 32'h1000, 32'h1000, 2, 15, 1};
      tv[5]  = '{1, 1, 32'h1000, 32'h1000, 3, 15, 1};
      tv[6]  = '{1, 1, 32'h1000, 32'h1000, 3, 15, 1};
      tv[7]  = '{0, 0, 32'h0, 32'h1000, 3, 15, 1};
      tv[8]  = '{1, 0, 32'h1000, 32'h1004, 1, 0, 0};
      tv[9]  = '{0, 0, 32'h0, 32'h1000, 1, 14, 0};
      tv[10] = '{0, 0, 32'h0, 32'hABCD_1000, 1, 14, 0};
      tv[11] = '{0, 0, 32'h0, 32'h40, 2, 0, 1};
      tv[12] = '{0, 0, 32'h0, 32'hC0, 2, 0, 1};
      tv[13] = '{0, 0, 32'h0, 32'h1C0, 2, 0, 1};
      tv[14] = '{0, 0, 32'h0, 32'h3C0, 2, 0, 1};
      tv[15] = '{1, 0, 32'h1004, 32'h1004, 0, 0, 0};
      tv[16] = '{1, 0, 32'h1004, 32'h1004, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         uv[i] = 1'b0; ut[i] = 1'b0; upc[i] = '0; ppc[i] = 32'h1000;
      end
      uv[0] = 1'b1; ut[0] = 1'b1; upc[0] = 32'h1000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.rdy", int'(rdy0), 0);
      chk("rst.cnt", int'(cnt0), 0);
      chk("rst.hist", int'(hist0), 0);
      chk("rst.tkn", int'(tkn0), 0);
      // Updates stay asserted on u0 throughout init and must be dropped.
      wait_rdy(0, 256, "init.len");
      uv[0] = 1'b0;
      chk("init.rdy3", int'(rdy3), 1);
      step(0, 0, 0, 0, 32'h1000, 1, 0, 0, "post_init");
      step(3, 0, 0, 0, 32'h1000, 3, 0, 0, "c3.init");

      for (int i = 0; i < 17; i++)
         step(0, tv[i].uv, tv[i].ut, tv[i].upc, tv[i].ppc, tv[i].ec, tv[i].eh, int'(tv[i].et), $sformatf("v%0d", i));

      step(1, 1, 1, 32'h40, 32'h40, 1, 1, 0, "m1.a");
      step(1, 1, 0, 32'h40, 32'h40, 1, 2, 0, "m1.b");
      step(1, 1, 1, 32'h40, 32'h40, 1, 5, 0, "m1.c");
      step(1, 1, 0, 32'h40, 32'h40, 1, 10, 0, "m1.d");
      step(1, 1, 1, 32'h68, 32'h68, 1, 1, 0, "m1.e");
      step(1, 0, 0, 0, 32'h40, 2, 10, 1, "m1.idx1a");
      step(1, 0, 0, 0, 32'h68, 1, 1, 0, "m1.f");

      step(2, 1, 1, 32'h1000, 32'h1000, 1, 1, 0, "h1.a");
      step(2, 1, 1, 32'h1000, 32'h1000, 2, 1, 1, "h1.b");
      step(2, 1, 1, 32'h1000, 32'h1000, 3, 1, 1, "h1.c");
      step(2, 1, 1, 32'h1000, 32'h1000, 3, 1, 1, "h1.sat");
      step(2, 0, 0, 0, 32'h1000, 3, 1, 1, "h1.e");

      step(3, 1, 1, 32'h1000, 32'h1000, 3, 1, 0, "c3.w0");
      step(3, 1, 1, 32'h1000, 32'h1000, 3, 3, 0, "c3.w1");
      step(3, 1, 1, 32'h1000, 32'h1000, 3, 7, 0, "c3.w2");
      step(3, 1, 1, 32'h1000, 32'h1000, 3, 15, 0, "c3.w3");
      for (int k = 4; k <= 8; k++)
         step(3, 1, 1, 32'h1000, 32'h1000, k > 7 ? 7 : k, 15, 1, $sformatf("c3.up%0d", k));
      for (int k = 2; k >= -1; k--)
         step(3, 1, 0, 32'h1004, 32'h1004, k < 0 ? 0 : k, 0, 0, $sformatf("c3.dn%0d", k));
      step(3, 0, 0, 0, 32'h1004, 0, 0, 0, "c3.end");

      // Flush with a same-PC update: no bypass, current tables shown, update lost.
      @(negedge clk);
      flush = 1'b1; uv[0] = 1'b1; ut[0] = 1'b1; upc[0] = 32'h1000; ppc[0] = 32'h1000;
      #1;
      chk("fl.hist", int'(hist0), 14);
      chk("fl.cnt", int'(cnt0), 1);
      @(posedge clk); #1;
      flush = 1'b0; uv[0] = 1'b0;
      chk("fl.rdy", int'(rdy0), 0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("fl.rdy100", int'(rdy0), 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_rdy(0, 256, "fl.restart");
      step(0, 0, 0, 0, 32'h1000, 1, 0, 0, "fl.a");
      step(0, 0, 0, 0, 32'h1004, 1, 0, 0, "fl.b");
      step(0, 0, 0, 0, 32'h3C0, 1, 0, 0, "fl.c");

      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      repeat (49) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_rdy(0, 256, "rst_in_init");
      step(0, 0, 0, 0, 32'h1000, 1, 0, 0, "rii.a");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
